// File: rtl/shift_row_pkg.sv
// shift_row_pkg: shared constants and helpers for the row delay line and window assembler
package shift_row_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_DEPTH = 256;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int clamp_depth(input int d, input int max_depth);
    return (d < 1) ? 1 : (d > max_depth) ? max_depth : d;
  endfunction
endpackage

// File: rtl/shift_row_ram.sv
// shift_row_ram: simple dual-port RAM, registered read port, read-before-write on collision
module shift_row_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  // Output register holds when not read; reset only clears it, never the array
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/shift_row_buffer.sv
// shift_row_buffer: valid-gated runtime-depth row delay line with fill tracking and flush
module shift_row_buffer
  import shift_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int DEPTH_W = clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DEPTH_W-1:0]    cfg_depth,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  primed,
  output logic [DEPTH_W-1:0]    fill_count
);
  localparam int AW = clog2(MAX_DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_addr;
  logic [DEPTH_W-1:0] depth_q, depth_d, depth_clamped, fill_q, fill_d, wr_ext, rd_full;
  logic out_valid_q, out_valid_d, accept;
  assign accept = in_valid & ~rst & ~flush;
  assign primed = (fill_q == depth_q);
  assign depth_clamped = DEPTH_W'(clamp_depth(int'(cfg_depth), MAX_DEPTH));
  always_comb begin
    depth_d = flush ? depth_clamped : depth_q;
    wr_ptr_d = flush ? '0 : !accept ? wr_ptr_q : (wr_ptr_q == AW'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    fill_d = flush ? '0 : (accept && !primed) ? fill_q + 1'b1 : fill_q;
    out_valid_d = accept & primed;
    // Modular subtraction that also works for non-power-of-two MAX_DEPTH
    wr_ext = DEPTH_W'(wr_ptr_q);
    rd_full = (wr_ext >= depth_q) ? wr_ext - depth_q : wr_ext + (DEPTH_W'(MAX_DEPTH) - depth_q);
    rd_addr = AW'(rd_full);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= depth_clamped;
      wr_ptr_q <= '0;
      fill_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end
  shift_row_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(MAX_DEPTH),
    .AW(AW)
  ) u_ram (
    .clk(clk),
    .rst(rst),
    .we(accept),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .re(out_valid_d),
    .raddr(rd_addr),
    .rdata(data_out)
  );
  assign out_valid = out_valid_q;
  assign fill_count = fill_q;
endmodule

// File: tb/tb_shift_row_buffer.sv
// tb_shift_row_buffer: table vectors plus history-model scoreboard for shift_row_buffer
module tb_shift_row_buffer;
  localparam int MD = 8;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0;
  logic [3:0] cfg_depth = 4'd3;
  logic [15:0] data_in = '0, data_out;
  logic out_valid, primed;
  logic [3:0] fill_count;
  int passed = 0, total = 0;
  int m_fill = 0, m_depth = 1, m_cnt = 0;
  bit m_valid = 0;
  int m_data = 0;
  int hist [4096];
  int sb [$];
  typedef struct {bit r; bit f; bit iv; int c; int d; bit ev; int eo; int ef;} vec_t;
  vec_t vt [24];

  shift_row_buffer #(.DATA_WIDTH(16), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cfg_depth(cfg_depth), .in_valid(in_valid),
    .data_in(data_in), .data_out(data_out), .out_valid(out_valid), .primed(primed),
    .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  function automatic int clampd(input int c);
    return (c == 0) ? 1 : (c > MD) ? MD : c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input bit r, input bit f, input bit iv, input int c, input int d);
    rst = r; flush = f; in_valid = iv; cfg_depth = 4'(c); data_in = 16'(d);
    if (r || f) begin
      m_fill = 0; m_cnt = 0; m_valid = 0; m_depth = clampd(c);
      if (r) m_data = 0;
    end else if (iv) begin
      hist[m_cnt % 4096] = d & 16'hffff;
      if (m_fill == m_depth) begin
        m_data = hist[(m_cnt - m_depth) % 4096];
        m_valid = 1;
        sb.push_back(m_data);
      end else begin
        m_fill++;
        m_valid = 0;
      end
      m_cnt++;
    end else m_valid = 0;
    @(posedge clk); #1;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("fill_count", int'(fill_count), m_fill);
    check("primed", int'(primed), int'(m_fill == m_depth));
    check("data_out", int'(data_out), m_data);
    if (out_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got out_valid=1 expected no pending sample");
      end else check("sb_data", int'(data_out), sb.pop_front());
    end
  endtask

  initial begin
    vt[0]  = '{1,0,0,3,0, 0,0,0};
    vt[1]  = '{0,0,1,0,10,0,0,1};
    vt[2]  = '{0,0,0,0,20,0,0,1};
    vt[3]  = '{0,0,1,0,30,0,0,2};
    vt[4]  = '{0,0,1,0,40,0,0,3};
    vt[5]  = '{0,0,0,0,50,0,0,3};
    vt[6]  = '{0,0,0,0,60,0,0,3};
    vt[7]  = '{0,0,1,0,70,1,10,3};
    vt[8]  = '{0,0,1,0,80,1,30,3};
    vt[9]  = '{0,0,0,0,0, 0,30,3};
    vt[10] = '{0,0,1,0,90,1,40,3};
    vt[11] = '{1,1,1,2,99,0,0,0};
    vt[12] = '{0,0,1,0,1, 0,0,1};
    vt[13] = '{0,0,1,0,2, 0,0,2};
    vt[14] = '{0,0,1,0,3, 1,1,2};
    vt[15] = '{0,0,1,0,4, 1,2,2};
    vt[16] = '{0,0,1,0,5, 1,3,2};
    vt[17] = '{0,1,1,4,6, 0,3,0};
    vt[18] = '{0,0,1,0,7, 0,3,1};
    vt[19] = '{0,0,1,0,8, 0,3,2};
    vt[20] = '{0,0,1,0,9, 0,3,3};
    vt[21] = '{0,0,1,0,10,0,3,4};
    vt[22] = '{0,0,1,0,11,1,7,4};
    vt[23] = '{0,0,1,0,12,1,8,4};
    for (int i = 0; i < 24; i++) begin
      step(vt[i].r, vt[i].f, vt[i].iv, vt[i].c, vt[i].d);
      check("tbl_valid", int'(out_valid), int'(vt[i].ev));
      check("tbl_data", int'(data_out), vt[i].eo);
      check("tbl_fill", int'(fill_count), vt[i].ef);
    end
    // Continuous stream D=3: data_out tracks input-3
    step(1, 0, 0, 3, 0);
    for (int i = 1; i <= 20; i++) step(0, 0, 1, 0, i);
    // D = MAX_DEPTH across several pointer wraps
    step(1, 0, 0, 8, 0);
    for (int i = 1; i <= 30; i++) step(0, 0, 1, 0, i * 7 + 100);
    // Oversized request clamps to MAX_DEPTH, with stalls
    step(1, 0, 0, 12, 0);
    for (int i = 1; i <= 30; i++) step(0, 0, ($urandom_range(0, 3) != 0), 0, i + 500);
    // Zero request behaves as depth 1
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) step(0, 0, 1, 0, i * 3);
    // Reset mid-stream while primed overrides flush and in_valid
    step(1, 0, 0, 3, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, i + 40);
    step(1, 1, 1, 5, 777);
    check("rst_mid_data", int'(data_out), 0);
    check("rst_mid_fill", int'(fill_count), 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, i + 60);
    // Random traffic with occasional flush/reset and depth changes
    for (int i = 0; i < 400; i++) begin
      int rr;
      rr = $urandom_range(0, 99);
      step(rr < 2, rr >= 2 && rr < 5, $urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 65535));
    end
    step(0, 0, 0, 0, 0);
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
